demux_escritor_colas: RTL and testbench

//  Ingress-side writer for the weighted round-robin queue system.

---
 rtl/demux_escritor_colas_if.sv | 25 ++
 rtl/demux_escritor_colas.sv | 139 +++++++++++++
 tb/tb_demux_escritor_colas.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/demux_escritor_colas_if.sv
// Ingress/egress bus of the queue writer: incoming word handshake and
// the per-FIFO push/full side.
interface demux_escritor_colas_if #(
  parameter int unsigned QUEUE_QUANTITY = 4,
  parameter int unsigned DATA_BITS      = 8
);
  logic [DATA_BITS-1:0]      data_in;
  logic                      valid_in;
  logic                      ready_out;
  logic [QUEUE_QUANTITY-1:0] buf_full;
  logic [QUEUE_QUANTITY-1:0] push;
  logic [DATA_BITS-1:0]      data_out;

  // Upstream source plus FIFO bank as seen from outside the writer
  modport master (
    output data_in, valid_in, buf_full,
    input  ready_out, push, data_out
  );

  // The writer itself
  modport slave (
    input  data_in, valid_in, buf_full,
    output ready_out, push, data_out
  );
endinterface

// File: rtl/demux_escritor_colas.sv
// Queue writer: classifies words by their top bits, stages one word and pushes it
// into the matching FIFO, discarding words blocked longer than MAX_ESPERA cycles.
module demux_escritor_colas #(
  parameter int unsigned QUEUE_QUANTITY = 4,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned MAX_ESPERA     = 8,
  parameter int unsigned CNT_BITS       = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enb,
  demux_escritor_colas_if.slave              bus,
  output logic                               descarte,
  output logic [QUEUE_QUANTITY*CNT_BITS-1:0] contador_descartes,
  output logic [1:0]                         estado
);

  localparam int unsigned CLS_BITS  = $clog2(QUEUE_QUANTITY);
  localparam int unsigned WAIT_BITS = $clog2(MAX_ESPERA + 1);
  localparam logic [WAIT_BITS-1:0] WAIT_MAX = WAIT_BITS'(MAX_ESPERA);

  typedef enum logic [1:0] {
    VACIO     = 2'b00,
    LISTO     = 2'b01,
    BLOQUEADO = 2'b10
  } state_t;

  state_t                    state_q, state_d;
  logic [DATA_BITS-1:0]      data_q, data_d;
  logic [WAIT_BITS-1:0]      wait_q, wait_d;
  logic [CNT_BITS-1:0]       cnt_q [QUEUE_QUANTITY];
  logic [CNT_BITS-1:0]       cnt_d [QUEUE_QUANTITY];

  logic [CLS_BITS-1:0]       cls;
  logic                      bloq;
  logic                      push_ok;
  logic                      ready;
  logic                      accept;
  logic [QUEUE_QUANTITY-1:0] push_w;
  logic                      descarte_w;

  assign cls  = data_q[DATA_BITS-1 -: CLS_BITS];
  assign bloq = bus.buf_full[cls];

  // Handshake terms are combinational so a push and a new accept share one edge
  always_comb begin
    push_ok = 1'b0;
    ready   = 1'b0;
    accept  = 1'b0;
    push_w  = '0;
    if (rst && enb) begin
      push_ok = (state_q != VACIO) && !bloq;
      ready   = (state_q == VACIO) || push_ok;
      accept  = bus.valid_in && ready;
      if (push_ok) begin
        push_w[cls] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    wait_d     = wait_q;
    cnt_d      = cnt_q;
    descarte_w = 1'b0;
    if (enb) begin
      unique case (state_q)
        VACIO: begin
          if (accept) begin
            state_d = LISTO;
            data_d  = bus.data_in;
            wait_d  = '0;
          end
        end
        LISTO, BLOQUEADO: begin
          if (push_ok) begin
            wait_d = '0;
            if (accept) begin
              state_d = LISTO;
              data_d  = bus.data_in;
            end else begin
              state_d = VACIO;
            end
          end else if (state_q == LISTO) begin
            state_d = BLOQUEADO;
            wait_d  = WAIT_BITS'(1);
          end else if (wait_q < WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
          end else begin
            // Timeout: drop the staged word (data_out keeps it) and count it
            descarte_w = rst;
            state_d    = VACIO;
            wait_d     = '0;
            if (cnt_q[cls] != '1) begin
              cnt_d[cls] = cnt_q[cls] + 1'b1;
            end
          end
        end
        default: begin
          state_d = VACIO;
          wait_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= VACIO;
      data_q  <= '0;
      wait_q  <= '0;
      for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      wait_q  <= wait_d;
      for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    contador_descartes = '0;
    for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
      contador_descartes[i*CNT_BITS +: CNT_BITS] = cnt_q[i];
    end
  end

  assign bus.push      = push_w;
  assign bus.ready_out = ready;
  assign bus.data_out  = data_q;
  assign descarte      = descarte_w;
  assign estado        = state_q;

endmodule

// File: tb/tb_demux_escritor_colas.sv
// Directed bench for demux_escritor_colas: reset, streaming, stall, timeout,
// enable pause, counter saturation, full-release race and mid-operation reset.
module tb_demux_escritor_colas;

  localparam int unsigned QQ  = 4;
  localparam int unsigned DB  = 8;
  localparam int unsigned MAX = 8;
  localparam int unsigned CB  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            enb;
  logic            descarte;
  logic [QQ*CB-1:0] contador;
  logic [1:0]      estado;

  int n_cmp = 0;
  int n_err = 0;

  demux_escritor_colas_if #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB)) bus_if ();

  demux_escritor_colas #(
    .QUEUE_QUANTITY(QQ),
    .DATA_BITS     (DB),
    .MAX_ESPERA    (MAX),
    .CNT_BITS      (CB)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enb               (enb),
    .bus               (bus_if),
    .descarte          (descarte),
    .contador_descartes(contador),
    .estado            (estado)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] words [4]    = '{8'h05, 8'h47, 8'h8A, 8'hC3};
  logic [3:0] exp_push [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [7:0] cnt_sel;

  initial begin
    rst              = 1'b0;
    enb              = 1'b1;
    bus_if.valid_in  = 1'b1;
    bus_if.data_in   = 8'h00;
    bus_if.buf_full  = '0;

    // Reset held two cycles with valid_in asserted
    tick();
    tick();
    check_val("rst_push", 64'(bus_if.push), 64'h0);
    check_val("rst_ready", 64'(bus_if.ready_out), 64'h0);
    check_val("rst_estado", 64'(estado), 64'h0);
    check_val("rst_cnt", 64'(contador), 64'h0);
    check_val("rst_desc", 64'(descarte), 64'h0);
    check_val("rst_dout", 64'(bus_if.data_out), 64'h0);

    // Streaming, one word per cycle
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        bus_if.valid_in = 1'b1;
        bus_if.data_in  = words[i];
      end else begin
        bus_if.valid_in = 1'b0;
      end
      #1;
      check_val("str_ready", 64'(bus_if.ready_out), 64'h1);
      if (i > 0) begin
        check_val("str_push", 64'(bus_if.push), 64'(exp_push[i-1]));
        check_val("str_dout", 64'(bus_if.data_out), 64'(words[i-1]));
      end
      tick();
    end
    check_val("str_idle_estado", 64'(estado), 64'h0);
    check_val("str_idle_push", 64'(bus_if.push), 64'h0);
    check_val("str_hold_dout", 64'(bus_if.data_out), 64'hC3);

    // Stall on queue 2, released after three blocked cycles
    bus_if.buf_full = 4'b0100;
    bus_if.valid_in = 1'b1;
    bus_if.data_in  = 8'h8A;
    #1;
    check_val("stl_ready0", 64'(bus_if.ready_out), 64'h1);
    tick();
    bus_if.valid_in = 1'b0;
    #1;
    check_val("stl_listo", 64'(estado), 64'h1);
    check_val("stl_push0", 64'(bus_if.push), 64'h0);
    check_val("stl_ready1", 64'(bus_if.ready_out), 64'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_val("stl_estado", 64'(estado), 64'h2);
      check_val("stl_ready", 64'(bus_if.ready_out), 64'h0);
      check_val("stl_desc", 64'(descarte), 64'h0);
      tick();
    end
    bus_if.buf_full = '0;
    #1;
    check_val("stl_push", 64'(bus_if.push), 64'b0100);
    check_val("stl_dout", 64'(bus_if.data_out), 64'h8A);
    check_val("stl_desc_rel", 64'(descarte), 64'h0);
    check_val("stl_ready_rel", 64'(bus_if.ready_out), 64'h1);
    tick();
    check_val("stl_end_estado", 64'(estado), 64'h0);

    // Timeout on queue 3
    bus_if.buf_full = 4'b1000;
    bus_if.valid_in = 1'b1;
    bus_if.data_in  = 8'hC0;
    #1;
    tick();
    bus_if.valid_in = 1'b0;
    for (int i = 0; i <= int'(MAX); i++) begin
      #1;
      check_val("to_desc", 64'(descarte), 64'(i == int'(MAX)));
      check_val("to_push", 64'(bus_if.push), 64'h0);
      check_val("to_estado", 64'(estado), (i == 0) ? 64'h1 : 64'h2);
      tick();
    end
    cnt_sel = contador[31:24];
    check_val("to_estado_end", 64'(estado), 64'h0);
    check_val("to_cnt3", 64'(cnt_sel), 64'h1);

    // Enable paused four cycles while blocked: discard slips by four cycles
    bus_if.valid_in = 1'b1;
    bus_if.data_in  = 8'hC1;
    #1;
    tick();
    bus_if.valid_in = 1'b1;
    for (int i = 0; i <= int'(MAX) + 4; i++) begin
      enb = !(i >= 3 && i <= 6);
      #1;
      check_val("enb_desc", 64'(descarte), 64'(i == int'(MAX) + 4));
      check_val("enb_push", 64'(bus_if.push), 64'h0);
      if (!enb) begin
        check_val("enb_ready", 64'(bus_if.ready_out), 64'h0);
        check_val("enb_estado", 64'(estado), 64'h2);
      end
      tick();
    end
    enb             = 1'b1;
    bus_if.valid_in = 1'b0;
    #1;
    cnt_sel = contador[31:24];
    check_val("enb_cnt3", 64'(cnt_sel), 64'h2);
    check_val("enb_estado_end", 64'(estado), 64'h0);

    // 260 timeouts on queue 0: counter saturates at FF
    bus_if.buf_full = 4'b0001;
    for (int n = 0; n < 260; n++) begin
      bus_if.valid_in = 1'b1;
      bus_if.data_in  = 8'h11;
      #1;
      tick();
      bus_if.valid_in = 1'b0;
      repeat (MAX) tick();
      check_val("sat_desc", 64'(descarte), 64'h1);
      tick();
      cnt_sel = contador[7:0];
      if (n == 253) check_val("sat_cnt254", 64'(cnt_sel), 64'hFE);
      if (n == 254) check_val("sat_cnt255", 64'(cnt_sel), 64'hFF);
    end
    check_val("sat_all", 64'(contador), 64'h0200_00FF);

    // Full flag drops on the timeout cycle: push wins
    bus_if.valid_in = 1'b1;
    bus_if.data_in  = 8'h12;
    #1;
    tick();
    bus_if.valid_in = 1'b0;
    repeat (MAX) tick();
    bus_if.buf_full = '0;
    #1;
    check_val("race_push", 64'(bus_if.push), 64'b0001);
    check_val("race_desc", 64'(descarte), 64'h0);
    check_val("race_dout", 64'(bus_if.data_out), 64'h12);
    tick();
    check_val("race_estado", 64'(estado), 64'h0);
    check_val("race_cnt", 64'(contador), 64'h0200_00FF);

    // Reset while a word is blocked: word lost, counters cleared
    bus_if.buf_full = 4'b0100;
    bus_if.valid_in = 1'b1;
    bus_if.data_in  = 8'h80;
    #1;
    tick();
    bus_if.valid_in = 1'b0;
    tick();
    tick();
    check_val("mrst_pre", 64'(estado), 64'h2);
    rst = 1'b0;
    #1;
    check_val("mrst_ready", 64'(bus_if.ready_out), 64'h0);
    check_val("mrst_push", 64'(bus_if.push), 64'h0);
    tick();
    check_val("mrst_estado", 64'(estado), 64'h0);
    check_val("mrst_cnt", 64'(contador), 64'h0);
    rst             = 1'b1;
    bus_if.buf_full = '0;
    #1;
    check_val("mrst_ready1", 64'(bus_if.ready_out), 64'h1);
    check_val("mrst_nopush", 64'(bus_if.push), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
